// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control FSM.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields/flags in, strobes and selects out.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] state;
  logic       illegal;

  // Controller side: reads IR fields and flags, drives the datapath controls.
  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state, illegal
  );

  // Datapath side.
  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// Maps the FSM's coarse ALUOp plus instruction funct bits to an ALU opcode.
module alu_op_decoder
  import multicycle_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7,
  output logic [2:0] alu_ctl
);

  // sub only for R-type with funct7 set; addi with the same bit pattern is add.
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctl = ({op5, funct7} == 2'b11) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl = ALU_SLT;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32I-subset datapath.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  aluop_t     alu_op;
  logic       branch, pc_update, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, src_a, src_b;
  logic [2:0] alu_ctl;

  // State register; reset parks the FSM in FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state controls; everything defaults to 0 / hold.
  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    case (state_q)
      S_FETCH: begin
        src_b      = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // old PC + imm: branch/jump target lands in ALUOut early
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC <- precomputed target; ALU makes old PC + 4 for the link write
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        src_a   = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    bus.ImmSrc = IMM_I;
    case (bus.op)
      OP_LW, OP_I: bus.ImmSrc = IMM_I;
      OP_SW:       bus.ImmSrc = IMM_S;
      OP_BEQ:      bus.ImmSrc = IMM_B;
      OP_JAL:      bus.ImmSrc = IMM_J;
      default:     bus.ImmSrc = IMM_I;
    endcase
  end

  alu_op_decoder u_alu_dec (
    .alu_op (alu_op),
    .funct3 (bus.funct3),
    .op5    (bus.op[5]),
    .funct7 (bus.funct7),
    .alu_ctl(alu_ctl)
  );

  // Write strobes are gated by rst_n so FETCH's mem_ready-driven IRWrite
  // cannot fire while reset is held.
  assign bus.PCWrite    = rst_n & ((branch & bus.Zero) | pc_update);
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.state      = state_q;
  assign bus.illegal    = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each step queues the
// expected state/control word; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [16:0] cw;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
  //  ALUControl, ImmSrc, RegWrite, illegal}
  function automatic logic [16:0] c(input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, sa, sb,
                                    input logic [2:0] alu,
                                    input logic [1:0] imm,
                                    input logic rw, ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  task automatic step(input string nm, input logic rst, mr, z,
                      input logic [3:0] st, input logic [16:0] w);
    exp_t e;
    rst_n         = rst;
    bus.mem_ready = mr;
    bus.Zero      = z;
    e.name = nm; e.st = st; e.cw = w;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bus.op = o; bus.funct3 = f3; bus.funct7 = f7;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [16:0] got;
      e   = sb_q.pop_front();
      got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
             bus.RegWrite, bus.illegal};
      n_vec++;
      if (bus.state !== e.st || got !== e.cw) begin
        n_err++;
        $display("FAIL %s: state got %0d want %0d, ctrl got %b want %b",
                 e.name, bus.state, e.st, got, e.cw);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.Zero = 1'b0;
    set_ir(7'b0000011, 3'b010, 1'b0);
    @(posedge clk); #1;

    // reset held with mem_ready high: no IRWrite/PCWrite
    step("rst",       0, 1, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));

    // lw with one fetch wait and one read wait
    step("lw_fwait",  1, 0, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("lw_fetch",  1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("lw_dec",    1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("lw_madr",   1, 0, 0, 2, c(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    step("lw_rwait",  1, 0, 0, 3, c(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    step("lw_read",   1, 1, 0, 3, c(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    step("lw_wb",     1, 0, 0, 4, c(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));

    // sw: MemWrite held across two wait cycles
    set_ir(7'b0100011, 3'b010, 1'b0);
    step("sw_fetch",  1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    step("sw_dec",    1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
    step("sw_madr",   1, 0, 0, 2, c(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
    step("sw_w0",     1, 0, 0, 5, c(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    step("sw_w1",     1, 0, 0, 5, c(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    step("sw_w2",     1, 1, 0, 5, c(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));

    // R-type sub
    set_ir(7'b0110011, 3'b000, 1'b1);
    step("sub_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("sub_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("sub_exec",  1, 0, 0, 6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0));
    step("sub_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

    // addi with funct7 bit set still adds
    set_ir(7'b0010011, 3'b000, 1'b1);
    step("addi_fetch",1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("addi_dec",  1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("addi_exec", 1, 0, 0, 8, c(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    step("addi_wb",   1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

    // slt / and / sll (R), ori (I): exec-cycle ALUControl
    set_ir(7'b0110011, 3'b010, 1'b0);
    step("slt_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("slt_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("slt_exec",  1, 0, 0, 6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b101,2'b00,0,0));
    step("slt_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
    set_ir(7'b0110011, 3'b111, 1'b0);
    step("and_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("and_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("and_exec",  1, 0, 0, 6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0,0));
    step("and_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
    set_ir(7'b0110011, 3'b001, 1'b1);
    step("sll_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("sll_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("sll_exec",  1, 0, 0, 6, c(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b00,0,0));
    step("sll_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
    set_ir(7'b0010011, 3'b110, 1'b0);
    step("ori_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("ori_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    step("ori_exec",  1, 0, 0, 8, c(0,0,0,0,2'b00,2'b10,2'b01,3'b011,2'b00,0,0));
    step("ori_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

    // beq taken then not taken
    set_ir(7'b1100011, 3'b000, 1'b0);
    step("beqt_fetch",1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0));
    step("beqt_dec",  1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0));
    step("beqt_br",   1, 0, 1, 10, c(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));
    step("beqn_fetch",1, 1, 1, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0));
    step("beqn_dec",  1, 0, 1, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0));
    step("beqn_br",   1, 0, 0, 10, c(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));

    // jal
    set_ir(7'b1101111, 3'b000, 1'b0);
    step("jal_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0));
    step("jal_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0));
    step("jal_jump",  1, 0, 0, 9, c(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
    step("jal_wb",    1, 0, 0, 7, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,0));

    // reset pulsed while MemWrite is active
    set_ir(7'b0100011, 3'b010, 1'b0);
    step("swr_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    step("swr_dec",   1, 0, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
    step("swr_madr",  1, 0, 0, 2, c(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
    step("swr_w0",    1, 0, 0, 5, c(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
    step("swr_rst",   0, 0, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
    step("swr_resume",1, 0, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));

    // illegal opcode: TRAP held until reset
    set_ir(7'b1111111, 3'b000, 1'b0);
    step("ill_fetch", 1, 1, 0, 0, c(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("ill_dec",   1, 1, 0, 1, c(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
    for (int i = 0; i < 3; i++)
      step("ill_trap",1, 1, 1, 11, c(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1));
    step("ill_rst",   0, 1, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
    step("ill_resume",1, 0, 0, 0, c(0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));

    // drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d records left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle RV32I-subset datapath: shared instruction/data memory, single ALU, instruction register (IR), old-PC register.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), addi-class I-type ALU, beq, jal.
- Issues per-state strobes and mux selects, and stalls on a memory-ready handshake.
- Sits between the IR/flag outputs of the datapath and its enables/selects.

Parameters:
- TRAP_ON_ILLEGAL, 1: when 1, an unsupported opcode parks the FSM in TRAP; when 0, it is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  1  IR[30].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and old-PC load enable.
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ALUControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1  register file write enable.
- state  out  4  current state, for debug.
- illegal  out  1  high while in TRAP.

Behaviour:
- Reset: state forced to FETCH asynchronously. While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0; illegal = 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11.
- Internal signals: ALUOp (00 add, 01 sub, 10 funct-decoded), Branch, PCUpdate.
- PCWrite = (Branch & Zero) | PCUpdate.
- Unlisted outputs are 0 in every state. Selects are don't-care when unused but must still be driven to the values listed.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - IRWrite = PCUpdate = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (precomputes branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP (or FETCH if TRAP_ON_ILLEGAL = 0)
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Goes to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1. Goes to FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1, held throughout the wait. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Goes to ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Goes to ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1. Goes to FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1. Goes to ALUWB (writes old PC + 4).
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1. Goes to FETCH.
- TRAP: illegal = 1, all strobes 0. Exits only via reset.
- ImmSrc is combinational from op in every state:
  - lw and I-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - otherwise 00
- ALU decoding from ALUOp:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3: 000 -> 001 if {op[5], funct7} = 11, else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - No latches: every path assigns ALUControl.
- Latency:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
  - each memory wait cycle adds 1
- Reset asserted mid-instruction: the FSM returns to FETCH immediately; no partial write strobe survives past the reset edge.

Decomposition:
- Package multicycle_pkg: state encodings, opcode constants, ALUOp codes, ALUControl codes, ImmSrc codes.
- One combinational sub-module, alu_op_decoder (inputs ALUOp, funct3, op5, funct7; output ALUControl), instantiated by the FSM.

Test Plan:
- lw: op = 0000011, mem_ready = 1 -> states 0,1,2,3,4,0; RegWrite = 1 and ResultSrc = 01 only in state 4; ImmSrc = 00.
- sw with mem_ready low for 2 cycles in MEMWRITE -> MemWrite = 1 for 3 consecutive cycles, then FETCH; RegWrite never 1.
- R-type sub: op = 0110011, funct3 = 000, funct7 = 1 -> ALUControl = 001 in EXECR. addi: op = 0010011, funct7 = 1 -> ALUControl = 000 in EXECI. slt: funct3 = 010 -> 101.
- beq: Zero = 1 in BEQ -> PCWrite = 1 for one cycle. Zero = 0 -> PCWrite = 0. Both runs return to FETCH after 3 cycles.
- jal: op = 1101111 -> PCWrite = 1 in JAL, RegWrite = 1 in ALUWB, ImmSrc = 11. Illegal op = 1111111 -> illegal = 1, state = 11, held until rst_n low.
- rst_n pulsed low during MEMWRITE -> state = 0 and MemWrite = 0 asynchronously; FETCH resumes after release.
